// File: rtl/reg_file_sb.sv
// Register file with busy-bit scoreboard: 1 write port, 2 combinational read ports, optional bypass/zero reg.
// Zero-cycle read latency; no backpressure, stalls are signalled to the control unit via BUSY1/BUSY2.
module reg_file_sb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  input  logic                  RESERVE,
  input  logic [ADDR_WIDTH-1:0] RESADDRESS,
  input  logic                  CLEAR,
  output logic                  BUSY1,
  output logic                  BUSY2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;

  logic wr_ok;
  logic rs_ok;
  logic rd1_zero;
  logic rd2_zero;
  logic rd1_byp;
  logic rd2_byp;

  assign wr_ok    = WRITE   && !((ZERO_REG != 0) && (INADDRESS  == '0));
  assign rs_ok    = RESERVE && !((ZERO_REG != 0) && (RESADDRESS == '0));
  assign rd1_zero = (ZERO_REG != 0) && (OUT1ADDRESS == '0);
  assign rd2_zero = (ZERO_REG != 0) && (OUT2ADDRESS == '0);
  assign rd1_byp  = (BYPASS != 0) && WRITE && (INADDRESS == OUT1ADDRESS) && !rd1_zero;
  assign rd2_byp  = (BYPASS != 0) && WRITE && (INADDRESS == OUT2ADDRESS) && !rd2_zero;

  // Reserve is applied after the write so a same-address pair leaves the register busy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else if (CLEAR) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[INADDRESS] <= IN;
        busy[INADDRESS] <= 1'b0;
      end
      if (rs_ok) busy[RESADDRESS] <= 1'b1;
    end
  end

  always_comb begin
    OUT1  = '0;
    BUSY1 = 1'b0;
    if (RESET && !rd1_zero) begin
      if (rd1_byp) begin
        OUT1 = IN;
      end else begin
        OUT1  = regs[OUT1ADDRESS];
        BUSY1 = busy[OUT1ADDRESS];
      end
    end
  end

  always_comb begin
    OUT2  = '0;
    BUSY2 = 1'b0;
    if (RESET && !rd2_zero) begin
      if (rd2_byp) begin
        OUT2 = IN;
      end else begin
        OUT2  = regs[OUT2ADDRESS];
        BUSY2 = busy[OUT2ADDRESS];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: three instances (bypass, no bypass, zero register) share one stimulus stream.
module tb_reg_file_sb;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       RESERVE;
  logic [2:0] RESADDRESS;
  logic       CLEAR;

  logic [7:0] out1 [3];
  logic [7:0] out2 [3];
  logic       busy1 [3];
  logic       busy2 [3];

  int checks   = 0;
  int failures = 0;

  localparam int DA = 0;  // BYPASS=1, ZERO_REG=0
  localparam int DN = 1;  // BYPASS=0, ZERO_REG=0
  localparam int DZ = 2;  // BYPASS=1, ZERO_REG=1

  typedef struct {
    string      tag;
    int         id;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1[0]), .OUT2(out2[0]),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .CLEAR(CLEAR), .BUSY1(busy1[0]), .BUSY2(busy2[0])
  );

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1[1]), .OUT2(out2[1]),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .CLEAR(CLEAR), .BUSY1(busy1[1]), .BUSY2(busy2[1])
  );

  reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1[2]), .OUT2(out2[2]),
    .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .CLEAR(CLEAR), .BUSY1(busy1[2]), .BUSY2(busy2[2])
  );

  // id = dut*4 + signal (0 OUT1, 1 OUT2, 2 BUSY1, 3 BUSY2)
  function automatic logic [7:0] obs(input int id);
    logic [7:0] v;
    v = '0;
    case (id % 4)
      0: v = out1[id / 4];
      1: v = out2[id / 4];
      2: v = {7'b0, busy1[id / 4]};
      default: v = {7'b0, busy2[id / 4]};
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int dut, input int sig, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.id  = dut * 4 + sig;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic push_rd(input string tag, input int dut, input int port,
                         input logic [7:0] d, input logic b);
    push(tag, dut, port - 1, d);
    push(tag, dut, port + 1, {7'b0, b});
  endtask

  task automatic drain();
    exp_t x;
    logic [7:0] o;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      o = obs(x.id);
      checks++;
      assert (o === x.exp) else begin
        failures++;
        $error("FAIL %s dut=%0d sig=%0d observed=%h expected=%h", x.tag, x.id / 4, x.id % 4, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; WRITE = 1'b0; INADDRESS = '0; IN = '0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0; RESERVE = 1'b0; RESADDRESS = '0; CLEAR = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      push_rd("reset_state", d, 1, 8'h00, 1'b0);
      push_rd("reset_state", d, 2, 8'h00, 1'b0);
    end
    #2 drain();
    tick();
    RESET = 1'b1;

    // Fill every register with 0xFF, reserving reg 5 on the last write
    for (int a = 0; a < 8; a++) begin
      WRITE = 1'b1; INADDRESS = 3'(a); IN = 8'hFF;
      if (a == 7) begin RESERVE = 1'b1; RESADDRESS = 3'd5; end
      tick();
    end
    WRITE = 1'b0; RESERVE = 1'b0; OUT1ADDRESS = 3'd5;
    push_rd("fill", DA, 1, 8'hFF, 1'b1);
    #1 drain();

    // Mid-cycle reset pulse clears everything before the next edge
    RESET = 1'b0;
    for (int a = 0; a < 4; a++) begin
      OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(a + 4);
      for (int d = 0; d < 3; d++) begin
        push_rd("async_reset", d, 1, 8'h00, 1'b0);
        push_rd("async_reset", d, 2, 8'h00, 1'b0);
      end
      #1 drain();
    end
    RESET = 1'b1; OUT1ADDRESS = 3'd5;
    push_rd("state_after_reset", DA, 1, 8'h00, 1'b0);
    #1 drain();

    // Write, then bypass vs no-bypass
    tick();
    WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h11;
    tick();
    IN = 8'd23; OUT1ADDRESS = 3'd2;
    push_rd("bypass_pre", DA, 1, 8'd23, 1'b0);
    push_rd("nobypass_pre", DN, 1, 8'h11, 1'b0);
    #1 drain();
    tick();
    push_rd("bypass_post", DA, 1, 8'd23, 1'b0);
    push_rd("nobypass_post", DN, 1, 8'd23, 1'b0);
    drain();
    WRITE = 1'b0;
    push_rd("read_idle", DA, 1, 8'd23, 1'b0);
    #1 drain();

    // Scoreboard: reserve reg 3, write it two cycles later
    RESERVE = 1'b1; RESADDRESS = 3'd3; OUT2ADDRESS = 3'd3;
    push_rd("reserve_not_yet", DA, 2, 8'h00, 1'b0);
    #1 drain();
    tick();
    RESERVE = 1'b0;
    push_rd("busy_cycle1", DA, 2, 8'h00, 1'b1);
    push_rd("busy_cycle1", DN, 2, 8'h00, 1'b1);
    #1 drain();
    tick();
    push_rd("busy_cycle2", DA, 2, 8'h00, 1'b1);
    drain();
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'd82;
    push_rd("wb_bypass", DA, 2, 8'd82, 1'b0);
    push_rd("wb_nobypass", DN, 2, 8'h00, 1'b1);
    #1 drain();
    tick();
    WRITE = 1'b0;
    push_rd("wb_done", DA, 2, 8'd82, 1'b0);
    push_rd("wb_done", DN, 2, 8'd82, 1'b0);
    #1 drain();

    // Same-cycle reserve and write to reg 1
    OUT1ADDRESS = 3'd1;
    WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'd45; RESERVE = 1'b1; RESADDRESS = 3'd1;
    tick();
    WRITE = 1'b0; RESERVE = 1'b0;
    push_rd("rsv_wr_same", DA, 1, 8'd45, 1'b1);
    push_rd("rsv_wr_same", DN, 1, 8'd45, 1'b1);
    #1 drain();
    WRITE = 1'b1; IN = 8'd67;
    push_rd("rewrite_bypass", DA, 1, 8'd67, 1'b0);
    push_rd("rewrite_nobypass", DN, 1, 8'd45, 1'b1);
    #1 drain();
    tick();
    WRITE = 1'b0;
    push_rd("rewrite_done", DA, 1, 8'd67, 1'b0);
    push_rd("rewrite_done", DN, 1, 8'd67, 1'b0);
    #1 drain();

    // Reserve and write to different registers
    WRITE = 1'b1; INADDRESS = 3'd7; IN = 8'h77; RESERVE = 1'b1; RESADDRESS = 3'd6;
    tick();
    WRITE = 1'b0; RESERVE = 1'b0; OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd7;
    push_rd("rsv_diff", DN, 1, 8'h00, 1'b1);
    push_rd("wr_diff", DN, 2, 8'h77, 1'b0);
    #1 drain();

    // CLEAR overrides a coincident write and reserve
    CLEAR = 1'b1; WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'd10; RESERVE = 1'b1; RESADDRESS = 3'd4;
    tick();
    CLEAR = 1'b0; WRITE = 1'b0; RESERVE = 1'b0;
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(a);
      push_rd("clear", DN, 1, 8'h00, 1'b0);
      push_rd("clear", DA, 2, 8'h00, 1'b0);
      #1 drain();
    end

    // Zero register: write and reserve to address 0
    tick();
    OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'h5A; RESERVE = 1'b1; RESADDRESS = 3'd0;
    push_rd("zero_wr_cycle", DZ, 1, 8'h00, 1'b0);
    push_rd("zero_wr_cycle", DZ, 2, 8'h00, 1'b0);
    push_rd("nonzero_bypass", DA, 1, 8'h5A, 1'b0);
    #1 drain();
    tick();
    push_rd("zero_held", DZ, 1, 8'h00, 1'b0);
    push_rd("zero_held", DZ, 2, 8'h00, 1'b0);
    drain();
    WRITE = 1'b0; RESERVE = 1'b0;
    push_rd("zero_after", DZ, 1, 8'h00, 1'b0);
    push_rd("zero_after", DZ, 2, 8'h00, 1'b0);
    push_rd("reg0_normal", DA, 1, 8'h5A, 1'b1);
    #1 drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
